pipe_skid_stage: RTL
====================

// Module: pipe_skid_stage
// PURPOSE
//   Elastic pipeline register for the multi-cycle/pipelined CPU datapath.
//   Carries a data word (a) and a control word (b) forward, like the plain stage
//   register, and adds the return path: a ready signal that propagates
//   backpressure from the consumer stage to the producer stage.
//   A 2-entry skid structure (main + skid slot) allows full throughput while
//   keeping in_ready registered, so no combinational ready path crosses stages.
// PARAMETERS
//   WIDTH_A  32  width of data word (in_a/out_a)
//   WIDTH_B  32  width of control word (in_b/out_b)
// PORTS
//   clock      in   1        single clock; all state updates on posedge
//   reset      in   1        synchronous, active-high reset
//   in_valid   in   1        producer presents a beat
//   in_ready   out  1        stage can accept a beat (registered)
//   in_a       in   WIDTH_A  data word from producer
//   in_b       in   WIDTH_B  control word from producer
//   out_valid  out  1        stage holds a beat for consumer
//   out_ready  in   1        consumer takes the beat this cycle
//   out_a      out  WIDTH_A  data word to consumer (main slot)
//   out_b      out  WIDTH_B  control word to consumer (main slot)
//   level      out  2        occupancy: 0, 1 or 2 beats held
//   flush      in   1        [only with PIPE_FLUSH_EN] discard all held beats
// BEHAVIOUR
//   - Beat accepted when in_valid&in_ready; taken when out_valid&out_ready.
//   - Reset (sync, highest priority): state EMPTY, out_valid=0, in_ready=1,
//     level=0, out_a=0, out_b=0, skid slot=0. Applies mid-transfer; held beats lost.
//   - States: EMPTY (level 0), BUSY (main valid, level 1), FULL (main+skid, level 2).
//   - EMPTY: accept -> main<=in, BUSY. No accept -> stay EMPTY.
//   - BUSY: accept&take -> main<=in, stay BUSY; accept only -> skid<=in, FULL;
//     take only -> EMPTY; neither -> hold.
//   - FULL: in_ready=0 (no accept possible); take -> main<=skid, BUSY; else hold.
//   - in_ready = registered (next_state != FULL); out_valid = (state != EMPTY).
//   - Latency: beat accepted at edge N is on out_a/out_b with out_valid from N+1.
//   - Order preserved; no beat dropped or duplicated; outputs stable while
//     out_valid&!out_ready.
//   - Throughput: 1 beat/cycle when out_ready held high.
//   - in_a/in_b ignored when no accept; no arithmetic, widths pass through unchanged.
// CONFIGURATION
//   PIPE_FLUSH_EN defined: flush port exists. flush=1 at edge -> state EMPTY,
//     level=0, out_valid=0, in_ready=1, out_a/out_b/skid cleared to 0 (bubble).
//     A beat offered in the flush cycle is dropped. Reset overrides flush.
//   PIPE_FLUSH_EN undefined: no flush port; stage drains only via out_ready.
// STRUCTURE
//   - Shared package pipe_pkg: state typedef (EMPTY=2'd0, BUSY=2'd1,
//     FULL=2'd2), level constants.
//   - One sub-module pipe_slot: WIDTH-parametric load-enable register with sync
//     clear; instantiated for main and skid slots (a+b concatenated).
//   - Top level holds FSM, in_ready register, slot mux (in vs skid into main).
// TESTING
//   1. Reset: reset=1 two cycles -> out_valid=0, in_ready=1, level=0, out_a=0.
//   2. Stream: out_ready=1, push a=1..8 back-to-back -> out_a 1..8 on
//      consecutive cycles, one cycle late, level stays 1.
//   3. Backpressure: out_ready=0, push a=0xA,0xB -> level=2, in_ready=0 next
//      cycle, out_a=0xA held; out_ready=1 -> 0xA then 0xB, no loss.
//   4. Simultaneous in FULL: out_ready=1 with in_valid=1 while FULL -> input
//      not accepted that cycle, state BUSY, out_a=skid value.
//   5. Reset mid-operation: FULL, assert reset -> next cycle level=0,
//      out_valid=0, in_ready=1; next push after reset emerges first.
//   6. [PIPE_FLUSH_EN] FULL, flush=1 with in_valid=1, a=0x55 -> level=0,
//      out_a=0, 0x55 never appears on out_a.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic skid pipeline stage.
//   state_t   : occupancy state of the stage (EMPTY / BUSY / FULL)
//   LEVEL_*   : occupancy values reported on the level output
//   level_of  : maps a state onto its occupancy count
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,   // nothing held
    BUSY  = 2'd1,   // main slot valid
    FULL  = 2'd2    // main and skid slots valid
  } state_t;

  localparam logic [1:0] LEVEL_EMPTY = 2'd0;
  localparam logic [1:0] LEVEL_ONE   = 2'd1;
  localparam logic [1:0] LEVEL_TWO   = 2'd2;

  function automatic logic [1:0] level_of(input state_t s);
    logic [1:0] lvl;
    case (s)
      BUSY:    lvl = LEVEL_ONE;
      FULL:    lvl = LEVEL_TWO;
      default: lvl = LEVEL_EMPTY;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// Load-enable storage register with synchronous clear.
// One instance holds one beat (data and control words concatenated).
// Ports:
//   clock  in   1      posedge clock
//   clear  in   1      synchronous clear to zero, wins over load
//   load   in   1      capture d on this edge
//   d      in   WIDTH  next value
//   q      out  WIDTH  stored value
module pipe_slot import pipe_pkg::*; #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clock) begin
    if (clear) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with a two-entry skid structure (main + skid).
// Forwards a data word (a) and a control word (b) with one cycle of latency
// and propagates backpressure through a registered in_ready, so no
// combinational ready path crosses the stage boundary.
// Optional feature: define PIPE_FLUSH_EN to add the flush port, which
// discards every held beat and clears both slots.
// Ports:
//   clock      in   1        posedge clock
//   reset      in   1        synchronous, active-high reset
//   in_valid   in   1        producer presents a beat
//   in_ready   out  1        stage can accept a beat (registered)
//   in_a       in   WIDTH_A  data word from producer
//   in_b       in   WIDTH_B  control word from producer
//   out_valid  out  1        stage holds a beat for consumer
//   out_ready  in   1        consumer takes the beat this cycle
//   out_a      out  WIDTH_A  data word to consumer (main slot)
//   out_b      out  WIDTH_B  control word to consumer (main slot)
//   level      out  2        occupancy: 0, 1 or 2
//   flush      in   1        only with PIPE_FLUSH_EN: drop all held beats
module pipe_skid_stage import pipe_pkg::*; #(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_B = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] in_a,
  input  logic [WIDTH_B-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_A-1:0] out_a,
  output logic [WIDTH_B-1:0] out_b,
`ifdef PIPE_FLUSH_EN
  input  logic               flush,
`endif
  output logic [1:0]         level
);

  localparam int W        = WIDTH_A + WIDTH_B;
  localparam int MAIN_IDX = 0;
  localparam int SKID_IDX = 1;

  state_t      state_reg;
  state_t      state_next;
  logic        in_ready_reg;
  logic        accept;
  logic        take;
  logic        main_from_skid;
  logic        clear;
  logic        slot_load [2];
  logic [W-1:0] slot_d   [2];
  logic [W-1:0] slot_q   [2];

`ifdef PIPE_FLUSH_EN
  assign clear = reset | flush;
`else
  assign clear = reset;
`endif

  assign out_valid = (state_reg != EMPTY);
  assign accept    = in_valid & in_ready_reg;
  assign take      = out_valid & out_ready;

  always_comb begin
    state_next            = state_reg;
    slot_load[MAIN_IDX]   = 1'b0;
    slot_load[SKID_IDX]   = 1'b0;
    main_from_skid        = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          slot_load[MAIN_IDX] = 1'b1;
          state_next          = BUSY;
        end
      end
      BUSY: begin
        case ({accept, take})
          2'b11: slot_load[MAIN_IDX] = 1'b1;   // pass-through, stay BUSY
          2'b10: begin                          // consumer stalled: park in skid
            slot_load[SKID_IDX] = 1'b1;
            state_next          = FULL;
          end
          2'b01: state_next = EMPTY;
          default: ;
        endcase
      end
      FULL: begin
        // in_ready is low here, so only the skid-to-main move can happen.
        if (take) begin
          slot_load[MAIN_IDX] = 1'b1;
          main_from_skid      = 1'b1;
          state_next          = BUSY;
        end
      end
      default: state_next = EMPTY;
    endcase
`ifdef PIPE_FLUSH_EN
    if (flush) begin
      state_next = EMPTY;
    end
`endif
  end

  assign slot_d[MAIN_IDX] = main_from_skid ? slot_q[SKID_IDX] : {in_a, in_b};
  assign slot_d[SKID_IDX] = {in_a, in_b};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      pipe_slot #(.WIDTH(W)) u_slot (
        .clock (clock),
        .clear (clear),
        .load  (slot_load[gi]),
        .d     (slot_d[gi]),
        .q     (slot_q[gi])
      );
    end
  endgenerate

  // in_ready is derived from the next state so it is already correct in the
  // first cycle after entering or leaving FULL.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != FULL);
    end
  end

  assign in_ready = in_ready_reg;
  assign out_a    = slot_q[MAIN_IDX][W-1:WIDTH_B];
  assign out_b    = slot_q[MAIN_IDX][WIDTH_B-1:0];
  assign level    = level_of(state_reg);

endmodule
